hwy_cntry_timed_ctrl: RTL and testbench
=======================================

# hwy_cntry_timed_ctrl

Parametrised, timer-driven successor to the highway/country-road intersection controller. It runs a six-phase Moore machine with programmable yellow time, all-red clearance, minimum highway green and maximum country green. A request latch remembers country-road sensor pulses too short to be seen at a phase boundary. It sits between the country-road sensor and the two light-head drivers, using the same light encoding as the existing controller.

## Interface
Parameters:
- YELLOW_CYC, default 3: cycles each yellow phase is shown; legal range 1..2^CNT_W-1.
- ALLRED_CYC, default 2: cycles of all-red clearance after each yellow; legal range 1..2^CNT_W-1.
- HWY_MIN_CYC, default 8: minimum highway green dwell; legal range 1..2^CNT_W-1.
- CNTRY_MAX_CYC, default 10: maximum country green dwell; legal range 1..2^CNT_W-1.
- CNT_W, default 8: phase-timer width.

Ports:
- clk, in, 1: sole clock; all state changes on its rising edge.
- clear, in, 1: reset, asynchronous and active-high.
- x, in, 1: country-road vehicle sensor; 1 = vehicle present.
- hwy, out, 2: highway light; RED=0, YELLOW=1, GREEN=2.
- cntry, out, 2: country light, same encoding.
- phase, out, 3: current state code, 0..5.
- cntry_wait, out, 1: request latch value.

## Operation
- Six states, each listed as code name (hwy/cntry):
  - 0 HG (GREEN/RED)
  - 1 HY (YELLOW/RED)
  - 2 AR1 (RED/RED)
  - 3 CG (RED/GREEN)
  - 4 CY (RED/YELLOW)
  - 5 AR2 (RED/RED)
- Codes 6 and 7 are unreachable. If ever present, they decode as HG outputs and go to HG on the next edge.
- Timer t (CNT_W bits):
  - Cleared to 0 on every edge that changes state.
  - Otherwise increments, saturating at 2^CNT_W-1; it never wraps.
- Effective request r = x | cntry_wait.
- Transitions, evaluated at each rising edge:
  - HG→HY when r=1 and t ≥ HWY_MIN_CYC-1; otherwise stay in HG.
  - HY→AR1 when t = YELLOW_CYC-1.
  - AR1→CG when t = ALLRED_CYC-1.
  - CG→CY when x=0, or when t = CNTRY_MAX_CYC-1. CG uses raw x only; cntry_wait is not consulted.
  - CY→AR2 when t = YELLOW_CYC-1.
  - AR2→HG when t = ALLRED_CYC-1.
- Request latch cntry_wait:
  - Set at any edge where x=1 and the state is not CG.
  - Cleared at the AR1→CG edge; clear wins over set on that edge.
  - Holds in CG.
- A vehicle arriving during CY or AR2 therefore sets cntry_wait. The country road gets another turn after highway minimum green, which prevents starvation by the max-green cut-off.
- Outputs hwy, cntry and phase decode from the state register only (Moore); x has no combinational path to any output. cntry_wait is a direct register output.

## Timing
- Reset (clear=1, immediate, no clock needed):
  - state=HG, t=0, cntry_wait=0.
  - hwy=2, cntry=0, phase=0.
- Release: the first rising edge with clear=0 evaluates normally.
- Dwell lengths:
  - Yellow is visible exactly YELLOW_CYC cycles.
  - All-red is visible exactly ALLRED_CYC cycles.
  - Highway green lasts at least HWY_MIN_CYC cycles.
  - Country green lasts at least 1 and at most CNTRY_MAX_CYC cycles.
- Response latency: x rising in HG after the minimum dwell is met gives hwy=YELLOW one edge later.
- clear asserted mid-phase aborts that phase immediately: outputs go to HG values asynchronously and the latch is dropped.
- There is never an instant where both hwy and cntry are non-RED.

## Test plan
Defaults apply (3/2/8/10).
- Reset: assert clear mid-CG without a clock edge → hwy=2, cntry=0, phase=0, cntry_wait=0 immediately; they hold while clear=1.
- Continuous x=1 from reset release → per-state cycle counts are HG 8, HY 3, AR1 2, CG 10 (max cut), CY 3, AR2 2. The sequence then repeats with HG again lasting 8 cycles.
- Single 1-cycle x pulse at HG t=2 → cntry_wait=1 from the next cycle. HG→HY occurs at the t=7 edge, and cntry_wait clears entering CG. CG lasts 1 cycle because x=0.
- Early country release: x=1 until CG t=3, then x=0 → CY entered at the edge where x is first sampled 0 (CG dwell 4). Cycle order is hwy RED throughout, then cntry GREEN→YELLOW→RED.
- x=1 pulse during AR2 → cntry_wait=1. Next HG lasts exactly 8 cycles, then HY follows with x=0.
- x held 0 for 300 cycles after reset → remains HG with hwy=2. t saturates at 255 with no wrap, and no spurious transition occurs.

Source files
------------

// File: rtl/hwy_cntry_timed_ctrl.sv
// Highway/country-road intersection controller: six-phase timed Moore FSM with
// programmable yellow, all-red, minimum highway green and maximum country green.
module hwy_cntry_timed_ctrl #(
  parameter int YELLOW_CYC    = 3,
  parameter int ALLRED_CYC    = 2,
  parameter int HWY_MIN_CYC   = 8,
  parameter int CNTRY_MAX_CYC = 10,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       x,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic [2:0] phase,
  output logic       cntry_wait
);

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } light_t;

  localparam logic [CNT_W-1:0] T_MAX     = '1;
  localparam logic [CNT_W-1:0] YEL_T     = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] AR_T      = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] HWY_MIN_T = CNT_W'(HWY_MIN_CYC - 1);
  localparam logic [CNT_W-1:0] CG_MAX_T  = CNT_W'(CNTRY_MAX_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] t;
  logic             req;

  assign req = x | cntry_wait;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      HG:      if (req && (t >= HWY_MIN_T)) state_nxt = HY;
      HY:      if (t == YEL_T)              state_nxt = AR1;
      AR1:     if (t == AR_T)               state_nxt = CG;
      CG:      if (!x || (t == CG_MAX_T))   state_nxt = CY;
      CY:      if (t == YEL_T)              state_nxt = AR2;
      AR2:     if (t == AR_T)               state_nxt = HG;
      default:                              state_nxt = HG;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= HG;
      t          <= '0;
      cntry_wait <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        t <= '0;
      else if (t != T_MAX)
        t <= t + 1'b1;
      // Clearing on entry to country green wins over a simultaneous sensor hit.
      if (state == AR1 && state_nxt == CG)
        cntry_wait <= 1'b0;
      else if (x && state != CG)
        cntry_wait <= 1'b1;
    end
  end

  always_comb begin
    hwy   = GREEN;
    cntry = RED;
    phase = 3'd0;
    case (state)
      HY:  begin hwy = YELLOW; cntry = RED;    phase = 3'd1; end
      AR1: begin hwy = RED;    cntry = RED;    phase = 3'd2; end
      CG:  begin hwy = RED;    cntry = GREEN;  phase = 3'd3; end
      CY:  begin hwy = RED;    cntry = YELLOW; phase = 3'd4; end
      AR2: begin hwy = RED;    cntry = RED;    phase = 3'd5; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hwy_cntry_timed_ctrl.sv
// Table-driven bench for hwy_cntry_timed_ctrl at default timing (3/2/8/10/8),
// plus hand sequences for timer saturation and asynchronous clear mid-phase.
module tb_hwy_cntry_timed_ctrl;

  logic       clk = 1'b0;
  logic       clear;
  logic       x;
  logic [1:0] hwy, cntry;
  logic [2:0] phase;
  logic       cntry_wait;

  hwy_cntry_timed_ctrl dut (
    .clk       (clk),
    .clear     (clear),
    .x         (x),
    .hwy       (hwy),
    .cntry     (cntry),
    .phase     (phase),
    .cntry_wait(cntry_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       xv;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] ph;
    logic       w;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // n identical vectors; lights come from the phase table (0 HG .. 5 AR2).
  function automatic void push(input int n, input logic clr, input logic xv,
                               input logic [2:0] ph, input logic w);
    vec_t v;
    v.clr = clr; v.xv = xv; v.ph = ph; v.w = w;
    case (ph)
      3'd0:    begin v.hwy = 2'd2; v.cntry = 2'd0; end
      3'd1:    begin v.hwy = 2'd1; v.cntry = 2'd0; end
      3'd3:    begin v.hwy = 2'd0; v.cntry = 2'd2; end
      3'd4:    begin v.hwy = 2'd0; v.cntry = 2'd1; end
      default: begin v.hwy = 2'd0; v.cntry = 2'd0; end
    endcase
    repeat (n) vecs.push_back(v);
  endfunction

  task automatic step(input logic xv);
    x = xv;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clear = 1'b1;
    x     = 1'b0;

    // Continuous demand: HG 8, HY 3, AR1 2, CG 10, CY 3, AR2 2, HG 8 again.
    push(1, 1, 1, 0, 0);
    push(7, 0, 1, 0, 1);
    push(3, 0, 1, 1, 1);
    push(2, 0, 1, 2, 1);
    push(10, 0, 1, 3, 0);
    push(1, 0, 1, 4, 0);
    push(2, 0, 1, 4, 1);
    push(2, 0, 1, 5, 1);
    push(8, 0, 1, 0, 1);
    push(1, 0, 1, 1, 1);
    // One-cycle pulse at HG t=2: latched, HY at the t=7 edge, CG lasts 1.
    push(1, 1, 0, 0, 0);
    push(2, 0, 0, 0, 0);
    push(1, 0, 1, 0, 1);
    push(4, 0, 0, 0, 1);
    push(3, 0, 0, 1, 1);
    push(2, 0, 0, 2, 1);
    push(1, 0, 0, 3, 0);
    push(3, 0, 0, 4, 0);
    push(2, 0, 0, 5, 0);
    push(2, 0, 0, 0, 0);
    // Early release after CG t=3, then a pulse in AR2 earns another turn.
    push(1, 1, 0, 0, 0);
    push(7, 0, 1, 0, 1);
    push(3, 0, 1, 1, 1);
    push(2, 0, 1, 2, 1);
    push(4, 0, 1, 3, 0);
    push(3, 0, 0, 4, 0);
    push(1, 0, 0, 5, 0);
    push(1, 0, 1, 5, 1);
    push(8, 0, 0, 0, 1);
    push(3, 0, 0, 1, 1);
    push(2, 0, 0, 2, 1);
    push(1, 0, 0, 3, 0);
    push(1, 0, 0, 4, 0);

    repeat (2) @(negedge clk);
    check("reset_hwy",   hwy,        2);
    check("reset_cntry", cntry,      0);
    check("reset_phase", phase,      0);
    check("reset_wait",  cntry_wait, 0);

    foreach (vecs[i]) begin
      clear = vecs[i].clr;
      step(vecs[i].xv);
      check($sformatf("vec%0d_hwy", i),   hwy,        vecs[i].hwy);
      check($sformatf("vec%0d_cntry", i), cntry,      vecs[i].cntry);
      check($sformatf("vec%0d_phase", i), phase,      vecs[i].ph);
      check($sformatf("vec%0d_wait", i),  cntry_wait, vecs[i].w);
      check($sformatf("vec%0d_safe", i),  (hwy != 2'd0) && (cntry != 2'd0), 0);
    end

    // No demand for 300 cycles: stay in HG, timer pins at 255.
    clear = 1'b1;
    step(1'b0);
    clear = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1'b0);
      check($sformatf("idle%0d_phase", i), phase, 0);
      check($sformatf("idle%0d_hwy", i),   hwy,   2);
    end
    check("idle_t_saturated", dut.t, 255);
    step(1'b1);
    check("idle_then_x_phase", phase, 1);
    check("idle_then_x_hwy",   hwy,   1);

    // Asynchronous clear in the middle of country green.
    clear = 1'b1;
    step(1'b0);
    clear = 1'b0;
    for (int i = 0; i < 40 && phase != 3'd3; i++) step(1'b1);
    check("reach_cg", phase, 3);
    step(1'b1);
    #2 clear = 1'b1;
    #1;
    check("async_hwy",   hwy,        2);
    check("async_cntry", cntry,      0);
    check("async_phase", phase,      0);
    check("async_wait",  cntry_wait, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check($sformatf("hold%0d_phase", i), phase,      0);
      check($sformatf("hold%0d_wait", i),  cntry_wait, 0);
    end
    clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
